// File: rtl/leaf_stream_sender.sv
// Credit-based stream sender for a BFT leaf: wraps user words into addressed
// packets, tracks remote buffer credits and replays the output on resend.
module leaf_stream_sender #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 3,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dest_port,
    input  logic [PAYLOAD_BITS-1:0]       din_leaf_user2sender,
    input  logic                          vld_user2sender,
    output logic                          ack_sender2user,
    output logic [PACKET_BITS-1:0]        dout_sender2bft,
    input  logic                          resend,
    input  logic [PACKET_BITS-1:0]        din_bft2sender,
    output logic [NUM_BRAM_ADDR_BITS:0]   credits,
    output logic                          err_credit_overflow,
    output logic [1:0]                    fsm_state
);

    localparam int ADDR_FIELD  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;
    localparam int PORT_LSB    = PAYLOAD_BITS + ADDR_FIELD;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int CW          = NUM_BRAM_ADDR_BITS + 1;
    localparam int SUMW        = CW + 1;
    localparam int MAX_CREDITS = 1 << NUM_BRAM_ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic                     credit_in;
    logic [SUMW-1:0]          credit_sum;
    logic                     credit_over;
    logic [PACKET_BITS-1:0]   next_pkt;
    logic                     unused_bits;

    // Only the valid bit and the port field identify a credit return.
    assign credit_in = din_bft2sender[PACKET_BITS-1] &&
                       (din_bft2sender[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(1));
    assign unused_bits = ^{din_bft2sender[PORT_LSB-1:0], din_bft2sender[PACKET_BITS-2:LEAF_LSB]};

    assign ack_sender2user = vld_user2sender && (credits != '0) && !resend && !reset;

    assign credit_sum  = SUMW'(credits)
                       + (credit_in ? SUMW'(FREESPACE_UPDATE_SIZE) : SUMW'(0))
                       - SUMW'(ack_sender2user);
    assign credit_over = credit_sum > SUMW'(MAX_CREDITS);

    assign next_pkt = {1'b1, dest_leaf, dest_port,
                       {(ADDR_FIELD - NUM_ADDR_BITS){1'b0}}, wr_addr,
                       din_leaf_user2sender};

    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            dout_sender2bft     <= '0;
            wr_addr             <= '0;
            credits             <= CW'(MAX_CREDITS);
            err_credit_overflow <= 1'b0;
        end else begin
            credits <= credit_over ? CW'(MAX_CREDITS) : credit_sum[CW-1:0];
            if (credit_over)
                err_credit_overflow <= 1'b1;
            if (ack_sender2user)
                wr_addr <= wr_addr + NUM_ADDR_BITS'(1);

            case (state)
                IDLE: begin
                    if (ack_sender2user) begin
                        state           <= SEND;
                        dout_sender2bft <= next_pkt;
                    end else begin
                        dout_sender2bft <= '0;
                    end
                end
                SEND, HOLD: begin
                    // A rejected packet stays on the output until the BFT takes it.
                    if (resend) begin
                        state <= HOLD;
                    end else if (ack_sender2user) begin
                        state           <= SEND;
                        dout_sender2bft <= next_pkt;
                    end else begin
                        state           <= IDLE;
                        dout_sender2bft <= '0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    dout_sender2bft <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/leaf_stream_sender.md
LEAF_STREAM_SENDER -- requirements
Module: leaf_stream_sender

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49, total BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32, user word width.
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 3, leaf id width.
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4, port id width.
REQ-005 SHALL have parameter NUM_ADDR_BITS, default 7, address field width.
REQ-006 SHALL have parameter NUM_BRAM_ADDR_BITS, default 7, remote receive buffer depth = 2^NUM_BRAM_ADDR_BITS.
REQ-007 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64, credits returned per credit packet.
REQ-008 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port dest_leaf, input, NUM_LEAF_BITS, destination leaf, static while traffic flows.
REQ-011 SHALL have port dest_port, input, NUM_PORT_BITS, destination input port (2..15), static while traffic flows.
REQ-012 SHALL have port din_leaf_user2sender, input, PAYLOAD_BITS, user payload.
REQ-013 SHALL have port vld_user2sender, input, 1, payload valid.
REQ-014 SHALL have port ack_sender2user, output, 1, payload accepted this cycle.
REQ-015 SHALL have port dout_sender2bft, output, PACKET_BITS, registered packet to BFT.
REQ-016 SHALL have port resend, input, 1, BFT rejected current output packet.
REQ-017 SHALL have port din_bft2sender, input, PACKET_BITS, packets from BFT (credit returns).
REQ-018 SHALL have port credits, output, NUM_BRAM_ADDR_BITS+1, current credit count.
REQ-019 SHALL have port err_credit_overflow, output, 1, sticky credit overflow flag.

Function
REQ-020 Packet layout SHALL be: [48] valid, [47:45] leaf, [44:41] port, [40:32] address (upper 2 bits zero, [38:32] = NUM_ADDR_BITS address), [31:0] payload.
REQ-021 ack_sender2user SHALL be combinational: vld_user2sender & (credits != 0) & ~resend.
REQ-022 On accept, next cycle dout_sender2bft SHALL carry valid=1, dest_leaf, dest_port, wr_addr, payload (latency 1).
REQ-023 wr_addr SHALL start at 0 and increment by 1 per accepted word, wrapping 127 -> 0.
REQ-024 With no accept and resend=0, next-cycle dout_sender2bft SHALL be all zeros.
REQ-025 While resend=1, dout_sender2bft SHALL hold its value unchanged, no accept, wr_addr and credits unchanged by sending.
REQ-026 Credit packet SHALL be din_bft2sender[48]=1 with port field == 1; other packets ignored.
REQ-027 Each credit packet SHALL add FREESPACE_UPDATE_SIZE to credits the following cycle.
REQ-028 Accept and credit packet in same cycle SHALL yield credits + FREESPACE_UPDATE_SIZE - 1.
REQ-029 Credits SHALL saturate at 2^NUM_BRAM_ADDR_BITS (128); overflow attempt SHALL set err_credit_overflow until reset.
REQ-030 credits == 0 SHALL block acceptance; user holds vld and data stable until ack.
REQ-031 State machine SHALL be IDLE (output empty), SEND (valid packet on output), HOLD (resend asserted); IDLE/SEND -> SEND on accept, -> IDLE otherwise; any state with valid output -> HOLD on resend; HOLD -> SEND/IDLE per accept when resend drops.

Reset
REQ-032 Reset SHALL asynchronously force dout_sender2bft=0, credits=128, wr_addr=0, err_credit_overflow=0, state IDLE.
REQ-033 Reset asserted mid-transfer SHALL discard the held packet; no packet re-emitted after release.
REQ-034 ack_sender2user SHALL be 0 while reset is high.

Verification
REQ-035 Reset, dest_leaf=3, dest_port=2, send payload 0xDEADBEEF -> next cycle dout = valid 1, leaf 3, port 2, addr 0, payload 0xDEADBEEF; credits=127.
REQ-036 Stream 128 words, no credit returns -> 128 acks, addrs 0..127, credits=0, 129th word unacknowledged with vld held.
REQ-037 At credits=0 inject one credit packet (port 1) -> credits=64, pending word accepted next cycle with addr 0 (wrapped).
REQ-038 Assert resend 3 cycles while packet addr 5 on output -> dout unchanged 3 cycles, no ack, then addr 6 follows.
REQ-039 At credits=100 inject credit packet -> credits=128, err_credit_overflow=1 until reset.
REQ-040 Accept and credit packet same cycle at credits=10 -> credits=73.
